mem_port_arbiter: RTL

Parametrised N-channel arbiter that merges the block-transfer miss/write-back ports of several caches (L1 I/D, L2 slices) onto one slow-memory port. Each channel uses the same read/write/addr/wdata → ready/rdata handshake as a cache's memory side, so a cache connects unchanged. Grant order is round-robin or fixed-priority, selected by parameter. The arbiter registers every transaction, so memory-side outputs are free of combinational paths from the requesters.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges N cache block-transfer ports onto one memory port.
// Every memory-side and requester-side output comes straight from a flop.
//
// state | meaning
// IDLE  | no transaction; pick a winner from current requests
// ISSUE | strobe held on memory port until mem_ready
// RESP  | one-cycle ch_ready pulse with captured read block
module mem_port_arbiter #(
    parameter int N_CH       = 2,
    parameter int AW         = 28,
    parameter int BW         = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    ch_read,
    input  logic [N_CH-1:0]    ch_write,
    input  logic [N_CH*AW-1:0] ch_addr,
    input  logic [N_CH*BW-1:0] ch_wdata,
    output logic [BW-1:0]      ch_rdata,
    output logic [N_CH-1:0]    ch_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic [AW-1:0]      mem_addr,
    output logic [BW-1:0]      mem_wdata,
    input  logic [BW-1:0]      mem_rdata,
    input  logic               mem_ready
);

    localparam int GW = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [BW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [N_CH-1:0]   ch_ready_q, ch_ready_d;
    logic [BW-1:0]     ch_rdata_q, ch_rdata_d;

    logic [N_CH-1:0]   req;
    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [AW-1:0]     sel_addr;
    logic [BW-1:0]     sel_wdata;
    logic              sel_write;
    logic [N_CH-1:0]   grant_oh;

    assign req = ch_read | ch_write;

    // Winner selection: lowest index, or first requester after last_grant with wrap.
    always_comb begin : p_winner
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        if (FIXED_PRIO != 0) begin
            for (int j = N_CH - 1; j >= 0; j--) begin
                if (req[j]) begin
                    win_found = 1'b1;
                    win_idx   = GW'(j);
                end
            end
        end else begin
            for (int off = 1; off <= N_CH; off++) begin
                idx = (int'(last_grant_q) + off) % N_CH;
                for (int j = 0; j < N_CH; j++) begin
                    if (!win_found && (j == idx) && req[j]) begin
                        win_found = 1'b1;
                        win_idx   = GW'(j);
                    end
                end
            end
        end
    end

    // Mux the winning channel's request fields and decode the held grant to one-hot.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        grant_oh  = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (win_idx == GW'(j)) begin
                sel_addr  = ch_addr[j*AW +: AW];
                sel_wdata = ch_wdata[j*BW +: BW];
                sel_write = ch_write[j];
            end
            grant_oh[j] = (grant_q == GW'(j));
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ch_ready_d   = '0;
        ch_rdata_d   = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d     = win_idx;
                    mem_write_d = sel_write;
                    mem_read_d  = !sel_write;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_write ? sel_wdata : '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    ch_rdata_d   = mem_read_q ? mem_rdata : '0;
                    ch_ready_d   = grant_oh;
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_CH - 1);
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ch_ready_q   <= '0;
            ch_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ch_ready_q   <= ch_ready_d;
            ch_rdata_q   <= ch_rdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ch_ready  = ch_ready_q;
    assign ch_rdata  = ch_rdata_q;

endmodule
